// File: rtl/register_file_param.sv
// Parametrised register file: one synchronous write port, two registered read
// ports with write-to-read bypass, optional hardwired zero register and a sweep clear engine.
module register_file_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  output logic              rvalid,
  input  logic              clear_req,
  output logic              busy
);

  localparam logic [0:0]        IDLE      = 1'b0;
  localparam logic [0:0]        CLEAR     = 1'b1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : gBadDepth
    $error("register_file_param: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W");
  end

  logic [WIDTH-1:0]  regArray [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;

  logic              isIdle;
  logic              wrAccept_p0;
  logic              rdEn_p0;
  logic [ADDR_W-1:0] rdIdx1_p0;
  logic [ADDR_W-1:0] rdIdx2_p0;
  logic [WIDTH-1:0]  rdNext1_p0;
  logic [WIDTH-1:0]  rdNext2_p0;

  logic [WIDTH-1:0]  rdData1_p1;
  logic [WIDTH-1:0]  rdData2_p1;
  logic              vld_p1;

  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_EXT;
  endfunction

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Out-of-range and zero-register reads win over the bypass, which wins over storage.
  function automatic logic [WIDTH-1:0] resolveRead(
    input logic [ADDR_W-1:0] addr,
    input logic              bypassHit,
    input logic [WIDTH-1:0]  bypassData,
    input logic [WIDTH-1:0]  stored
  );
    if (!inRange(addr) || isZeroReg(addr)) return '0;
    if (bypassHit)                         return bypassData;
    return stored;
  endfunction

  assign isIdle = (state == IDLE);
  assign busy   = (state == CLEAR);

  // Stage p0: request qualification and read-data selection
  always_comb begin
    wrAccept_p0 = !reset && isIdle && we && !clear_req &&
                  inRange(waddr) && !isZeroReg(waddr);
    rdEn_p0     = isIdle && re;
    rdIdx1_p0   = inRange(raddr1) ? raddr1 : '0;
    rdIdx2_p0   = inRange(raddr2) ? raddr2 : '0;
    rdNext1_p0  = resolveRead(raddr1, wrAccept_p0 && (waddr == raddr1),
                              wdata, regArray[rdIdx1_p0]);
    rdNext2_p0  = resolveRead(raddr2, wrAccept_p0 && (waddr == raddr2),
                              wdata, regArray[rdIdx2_p0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      if (ptr == LAST_PTR) begin
        state <= IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end else if (clear_req) begin
      state <= CLEAR;
      ptr   <= '0;
    end
  end

  // Storage is not reset; the clear sweep defines every entry.
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      regArray[ptr] <= '0;
    end else if (wrAccept_p0) begin
      regArray[waddr] <= wdata;
    end
  end

  // Stage p1: registered read outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rdData1_p1 <= '0;
      rdData2_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rdEn_p0;
      if (rdEn_p0) begin
        rdData1_p1 <= rdNext1_p0;
        rdData2_p1 <= rdNext2_p0;
      end
    end
  end

  assign rdata1 = rdData1_p1;
  assign rdata2 = rdData2_p1;
  assign rvalid = vld_p1;

endmodule
